// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage SRAM sequencer.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int HALF_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // A simultaneous read+write request is resolved as a write.
   function automatic op_t decode_op(input logic mem_write);
      return mem_write ? OP_WR : OP_RD;
   endfunction

endpackage

// File: rtl/sram_mem_sequencer_if.sv
// Bundle of pipeline-side request/response and SRAM pad signals for the sequencer.
interface sram_mem_sequencer_if #(
   parameter int SRAM_AW = 18
);
   import mips_pkg::*;

   logic               mem_read;
   logic               mem_write;
   logic [WORD_W-1:0]  addr;
   logic [WORD_W-1:0]  wdata;
   logic [WORD_W-1:0]  rdata;
   logic               freeze;
   logic [SRAM_AW-1:0] sram_addr;
   logic [HALF_W-1:0]  sram_dq_out;
   logic               sram_dq_oe;
   logic [HALF_W-1:0]  sram_dq_in;
   logic               sram_we_n;
   logic               sram_oe_n;

   modport master (
      output mem_read, mem_write, addr, wdata, sram_dq_in,
      input  rdata, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
   );

   modport slave (
      input  mem_read, mem_write, addr, wdata, sram_dq_in,
      output rdata, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
   );

endinterface

// File: rtl/sram_mem_sequencer_half.sv
// Timer and strobe generator for one 16-bit half access; reused for the LO and HI halves.
module sram_half_access
   import mips_pkg::*;
#(
   parameter int ACC_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  op_t  op,
   output logic last,
   output logic we_n,
   output logic oe_n,
   output logic dq_oe
);

   localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Cleared on the last cycle so the next half starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last  = run && (cnt == CNT_LAST);
   // we_n releases on the last cycle so address and data are held past the write edge.
   assign we_n  = !(run && (op == OP_WR) && !last);
   assign oe_n  = !(run && (op == OP_RD));
   assign dq_oe = run && (op == OP_WR);

endmodule

// File: rtl/sram_mem_sequencer.sv
// Splits each 32-bit load/store into low-then-high 16-bit SRAM accesses and freezes the pipeline meanwhile.
module sram_mem_sequencer
   import mips_pkg::*;
#(
   parameter int ACC_CYCLES = 2,
   parameter int SRAM_AW    = 18
) (
   input logic                 clk,
   input logic                 rst_n,
   sram_mem_sequencer_if.slave bus
);

   state_t             state;
   state_t             next_state;
   op_t                op;
   logic [SRAM_AW-2:0] word_addr;
   logic [WORD_W-1:0]  wdata_lat;
   logic [WORD_W-1:0]  rdata_q;
   logic [SRAM_AW-1:0] sram_addr_c;
   logic [HALF_W-1:0]  dq_out_c;
   logic               req;
   logic               start;
   logic               run;
   logic               last;
   logic               addr_unused;

   assign req         = bus.mem_read | bus.mem_write;
   assign start       = (state == IDLE) && req;
   assign run         = (state == LO) || (state == HI);
   assign addr_unused = ^{bus.addr[WORD_W-1:SRAM_AW+1], bus.addr[1:0]};

   sram_half_access #(
      .ACC_CYCLES(ACC_CYCLES)
   ) u_half (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .op   (op),
      .last (last),
      .we_n (bus.sram_we_n),
      .oe_n (bus.sram_oe_n),
      .dq_oe(bus.sram_dq_oe)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A dropped request lets the current half finish, then abandons the word without DONE.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (req) next_state = LO;
         LO:   if (last) next_state = req ? HI : IDLE;
         HI:   if (last) next_state = req ? DONE : IDLE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      sram_addr_c = '0;
      dq_out_c    = '0;
      unique case (state)
         LO: begin
            sram_addr_c = {word_addr, 1'b0};
            dq_out_c    = wdata_lat[HALF_W-1:0];
         end
         HI: begin
            sram_addr_c = {word_addr, 1'b1};
            dq_out_c    = wdata_lat[WORD_W-1:HALF_W];
         end
         default: begin
            sram_addr_c = '0;
            dq_out_c    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op <= OP_RD;
      end else if (start) begin
         op <= decode_op(bus.mem_write);
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         word_addr <= bus.addr[SRAM_AW:2];
         wdata_lat <= bus.wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (last && (op == OP_RD)) begin
         if (state == LO) begin
            rdata_q[HALF_W-1:0] <= bus.sram_dq_in;
         end else begin
            rdata_q[WORD_W-1:HALF_W] <= bus.sram_dq_in;
         end
      end
   end

   assign bus.sram_addr   = sram_addr_c;
   assign bus.sram_dq_out = dq_out_c;
   assign bus.rdata       = rdata_q;
   // Dropping freeze in DONE lets EXE/MEM advance exactly once per word.
   assign bus.freeze      = req && (state != DONE);

endmodule

// File: tb/tb_sram_mem_sequencer.sv
// Self-checking bench: SRAM pad models plus a word-level reference memory for two sequencer instances.
module tb_sram_mem_sequencer;
   import mips_pkg::*;

   localparam int AW = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_mem_sequencer_if #(.SRAM_AW(AW)) bus ();
   sram_mem_sequencer_if #(.SRAM_AW(AW)) bus4 ();

   sram_mem_sequencer #(.ACC_CYCLES(2), .SRAM_AW(AW)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   sram_mem_sequencer #(.ACC_CYCLES(4), .SRAM_AW(AW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   logic [15:0] sram  [4096];
   logic [15:0] sram4 [256];
   logic        pre_en = 1'b0, pre4_en = 1'b0;
   logic [11:0] pre_a = '0;
   logic [15:0] pre_d = '0;
   logic [31:0] ref_mem [int];
   int checks = 0, failures = 0, illegal_seen = 0;

   assign bus.sram_dq_in  = bus.sram_oe_n  ? 16'h0000 : sram[bus.sram_addr[11:0]];
   assign bus4.sram_dq_in = bus4.sram_oe_n ? 16'h0000 : sram4[bus4.sram_addr[7:0]];

   always @(posedge clk) begin
      if (pre_en) sram[pre_a] <= pre_d;
      else if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr[11:0]] <= bus.sram_dq_out;
   end

   always @(posedge clk) begin
      if (pre4_en) sram4[pre_a[7:0]] <= pre_d;
      else if (!bus4.sram_we_n && bus4.sram_dq_oe) sram4[bus4.sram_addr[7:0]] <= bus4.sram_dq_out;
   end

   always @(posedge clk) begin
      if (rst_n && bus.mem_read && bus.mem_write) begin
         illegal_seen <= illegal_seen + 1;
         $display("note: simultaneous mem_read and mem_write seen by decoder monitor");
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   function automatic int widx(input logic [31:0] a);
      return int'(a[AW:2]);
   endfunction

   task automatic drive(input int which, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (which == 0) begin
         bus.mem_read = rd; bus.mem_write = wr; bus.addr = a; bus.wdata = d;
      end else begin
         bus4.mem_read = rd; bus4.mem_write = wr; bus4.addr = a; bus4.wdata = d;
      end
   endtask

   task automatic sample(input int which, output logic f, output logic we, output logic oe,
                         output logic dqo, output logic [AW-1:0] sa, output logic [31:0] r);
      if (which == 0) begin
         f = bus.freeze; we = bus.sram_we_n; oe = bus.sram_oe_n;
         dqo = bus.sram_dq_oe; sa = bus.sram_addr; r = bus.rdata;
      end else begin
         f = bus4.freeze; we = bus4.sram_we_n; oe = bus4.sram_oe_n;
         dqo = bus4.sram_dq_oe; sa = bus4.sram_addr; r = bus4.rdata;
      end
   endtask

   task automatic preload(input int which, input logic [11:0] ha, input logic [15:0] d);
      pre_a = ha; pre_d = d;
      if (which == 0) pre_en = 1'b1; else pre4_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0; pre4_en = 1'b0;
   endtask

   // Starts just after a clock edge; returns just after the edge that ends DONE, request still held.
   task automatic access(input int which, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int done_at, output int we_lows, output int oe_lows,
                         output logic [31:0] rdw, output logic [AW-1:0] wa0, output logic [AW-1:0] wa1);
      logic f, we, oe, dqo;
      logic [AW-1:0] sa;
      logic [31:0] r;
      drive(which, rd, wr, a, d);
      done_at = -1; we_lows = 0; oe_lows = 0; rdw = '0; wa0 = '0; wa1 = '0;
      for (int c = 0; c < 40 && done_at < 0; c++) begin
         @(negedge clk);
         sample(which, f, we, oe, dqo, sa, r);
         if (!we) begin
            if (we_lows == 0) wa0 = sa;
            wa1 = sa;
            we_lows++;
         end
         if (!oe) oe_lows++;
         if (!f) begin
            done_at = c;
            rdw = r;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic f, we, oe, dqo;
      logic [AW-1:0] sa;
      logic [31:0] r;
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h400, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      sample(0, f, we, oe, dqo, sa, r);
      checks++; if (we !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", we); end
      checks++; if (oe !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b exp=1", oe); end
      checks++; if (dqo !== 1'b0) begin failures++; $display("FAIL reset_dq_oe got=%b exp=0", dqo); end
      checks++; if (sa !== '0) begin failures++; $display("FAIL reset_sram_addr got=%h exp=0", sa); end
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", r); end
      checks++; if (f !== 1'b1) begin failures++; $display("FAIL reset_freeze_req got=%b exp=1", f); end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      sample(0, f, we, oe, dqo, sa, r);
      checks++; if (f !== 1'b0) begin failures++; $display("FAIL reset_freeze_noreq got=%b exp=0", f); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int done_at, wl, ol;
      logic [31:0] rdw;
      logic [AW-1:0] w0, w1;
      preload(0, 12'h200, 16'h1234);
      preload(0, 12'h201, 16'hABCD);
      ref_mem[widx(32'h400)] = 32'hABCD1234;
      access(0, 1'b1, 1'b0, 32'h400, 32'h0, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (done_at !== 5) begin failures++; $display("FAIL read_latency got=%0d exp=5", done_at); end
      checks++; if (rdw !== ref_mem[widx(32'h400)]) begin failures++; $display("FAIL read_data got=%h exp=%h", rdw, ref_mem[widx(32'h400)]); end
      checks++; if (wl !== 0) begin failures++; $display("FAIL read_we_n_lows got=%0d exp=0", wl); end
      checks++; if (ol !== 4) begin failures++; $display("FAIL read_oe_n_lows got=%0d exp=4", ol); end
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int done_at, wl, ol;
      logic [31:0] rdw;
      logic [AW-1:0] w0, w1;
      access(0, 1'b0, 1'b1, 32'h404, 32'hDEADBEEF, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      ref_mem[widx(32'h404)] = 32'hDEADBEEF;
      checks++; if (done_at !== 5) begin failures++; $display("FAIL write_latency got=%0d exp=5", done_at); end
      checks++; if (wl !== 2) begin failures++; $display("FAIL write_we_n_lows got=%0d exp=2", wl); end
      checks++; if (w0 !== 18'h202 || w1 !== 18'h203) begin failures++; $display("FAIL write_addrs got=%h,%h exp=202,203", w0, w1); end
      checks++; if (sram[12'h202] !== 16'hBEEF || sram[12'h203] !== 16'hDEAD) begin failures++; $display("FAIL write_sram got=%h,%h exp=beef,dead", sram[12'h202], sram[12'h203]); end
      checks++; if (ol !== 0) begin failures++; $display("FAIL write_oe_n_lows got=%0d exp=0", ol); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int done_a, done_b, wl, ol, total;
      logic [31:0] rdw;
      logic [AW-1:0] w0, w1;
      time t0;
      t0 = $time;
      access(0, 1'b0, 1'b1, 32'h408, 32'hDEADBEEF, done_a, wl, ol, rdw, w0, w1);
      ref_mem[widx(32'h408)] = 32'hDEADBEEF;
      access(0, 1'b1, 1'b0, 32'h408, 32'h0, done_b, wl, ol, rdw, w0, w1);
      total = int'(($time - t0) / 10);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (done_a !== 5 || done_b !== 5) begin failures++; $display("FAIL b2b_latency got=%0d,%0d exp=5,5", done_a, done_b); end
      checks++; if (rdw !== ref_mem[widx(32'h408)]) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", rdw, ref_mem[widx(32'h408)]); end
      checks++; if (total !== 12) begin failures++; $display("FAIL b2b_total_cycles got=%0d exp=12", total); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_write();
      int done_at, wl, ol;
      logic [31:0] rdw;
      logic [AW-1:0] w0, w1, sa;
      logic f, we, oe, dqo;
      logic [31:0] r;
      access(0, 1'b0, 1'b1, 32'h40C, 32'h11112222, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'h40C, 32'h33334444);
      repeat (3) begin @(posedge clk); #1; end
      sample(0, f, we, oe, dqo, sa, r);
      checks++; if (we !== 1'b0 || sa !== 18'h207) begin failures++; $display("FAIL midrst_hi_active got=we%b/%h exp=we0/207", we, sa); end
      rst_n = 1'b0;
      #1;
      sample(0, f, we, oe, dqo, sa, r);
      checks++; if (we !== 1'b1 || dqo !== 1'b0 || sa !== '0) begin failures++; $display("FAIL midrst_abort got=we%b oe%b/%h exp=we1 oe0/0", we, dqo, sa); end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      ref_mem[widx(32'h40C)] = {16'h1111, 16'h4444};
      checks++; if (sram[12'h206] !== 16'h4444 || sram[12'h207] !== 16'h1111) begin failures++; $display("FAIL midrst_sram got=%h,%h exp=4444,1111", sram[12'h206], sram[12'h207]); end
      access(0, 1'b1, 1'b0, 32'h40C, 32'h0, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (rdw !== ref_mem[widx(32'h40C)] || done_at !== 5) begin failures++; $display("FAIL midrst_readback got=%h@%0d exp=%h@5", rdw, done_at, ref_mem[widx(32'h40C)]); end
      @(posedge clk); #1;
   endtask

   task automatic test_req_drop();
      int done_at, wl, ol, lows;
      logic [31:0] rdw, old;
      logic [AW-1:0] w0, w1, sa;
      logic f, we, oe, dqo;
      logic [31:0] r, nw;
      old = $urandom(); nw = $urandom();
      access(0, 1'b0, 1'b1, 32'h410, old, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b1, 32'h410, nw);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      sample(0, f, we, oe, dqo, sa, r);
      checks++; if (f !== 1'b0) begin failures++; $display("FAIL drop_freeze got=%b exp=0", f); end
      lows = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         sample(0, f, we, oe, dqo, sa, r);
         if (!we) lows++;
      end
      @(posedge clk); #1;
      checks++; if (lows !== 1) begin failures++; $display("FAIL drop_we_n_lows got=%0d exp=1", lows); end
      ref_mem[widx(32'h410)] = {old[31:16], nw[15:0]};
      access(0, 1'b1, 1'b0, 32'h410, 32'h0, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (rdw !== ref_mem[widx(32'h410)]) begin failures++; $display("FAIL drop_readback got=%h exp=%h", rdw, ref_mem[widx(32'h410)]); end
      @(posedge clk); #1;
   endtask

   task automatic test_acc4();
      int done_at, wl, ol;
      logic [31:0] rdw, d;
      logic [AW-1:0] w0, w1;
      d = $urandom();
      preload(1, 12'h010, 16'h5A5A);
      preload(1, 12'h011, 16'hC3C3);
      access(1, 1'b1, 1'b0, 32'h20, 32'h0, done_at, wl, ol, rdw, w0, w1);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (done_at !== 9) begin failures++; $display("FAIL acc4_read_latency got=%0d exp=9", done_at); end
      checks++; if (rdw !== 32'hC3C35A5A) begin failures++; $display("FAIL acc4_read_data got=%h exp=c3c35a5a", rdw); end
      checks++; if (ol !== 8 || wl !== 0) begin failures++; $display("FAIL acc4_read_strobes got=oe%0d we%0d exp=oe8 we0", ol, wl); end
      @(posedge clk); #1;
      access(1, 1'b0, 1'b1, 32'h28, d, done_at, wl, ol, rdw, w0, w1);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (done_at !== 9 || wl !== 6) begin failures++; $display("FAIL acc4_write_timing got=done%0d we%0d exp=done9 we6", done_at, wl); end
      checks++; if (w0 !== 18'h14 || w1 !== 18'h15) begin failures++; $display("FAIL acc4_write_addrs got=%h,%h exp=14,15", w0, w1); end
      @(posedge clk); #1;
      access(1, 1'b1, 1'b0, 32'h28, 32'h0, done_at, wl, ol, rdw, w0, w1);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (rdw !== d) begin failures++; $display("FAIL acc4_readback got=%h exp=%h", rdw, d); end
      @(posedge clk); #1;
   endtask

   task automatic test_idle_illegal();
      int done_at, wl, ol;
      logic [31:0] rdw, d;
      logic [AW-1:0] w0, w1, sa;
      logic f, we, oe, dqo;
      logic [31:0] r;
      d = $urandom();
      drive(0, 1'b0, 1'b0, $urandom(), $urandom());
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         sample(0, f, we, oe, dqo, sa, r);
         checks++;
         if (f !== 1'b0 || we !== 1'b1 || oe !== 1'b1 || dqo !== 1'b0) begin
            failures++; $display("FAIL idle_quiet c=%0d got=f%b we%b oe%b dqoe%b exp=f0 we1 oe1 dqoe0", c, f, we, oe, dqo);
         end
      end
      @(posedge clk); #1;
      access(0, 1'b1, 1'b1, 32'h414, d, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      ref_mem[widx(32'h414)] = d;
      checks++; if (wl !== 2 || ol !== 0 || done_at !== 5) begin failures++; $display("FAIL illegal_as_write got=we%0d oe%0d done%0d exp=we2 oe0 done5", wl, ol, done_at); end
      checks++; if (illegal_seen < 1) begin failures++; $display("FAIL illegal_flagged got=%0d exp>=1", illegal_seen); end
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 32'h414, 32'h0, done_at, wl, ol, rdw, w0, w1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (rdw !== ref_mem[widx(32'h414)]) begin failures++; $display("FAIL illegal_readback got=%h exp=%h", rdw, ref_mem[widx(32'h414)]); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int done_at, wl, ol, k, gap;
      logic [31:0] rdw, a, d;
      logic [AW-1:0] w0, w1;
      bit wr;
      for (int i = 0; i < 24; i++) begin
         k  = int'($urandom_range(7, 0));
         a  = ($urandom() & 32'hFFF8_0000) | (32'h500 + 32'(k * 4));
         wr = ($urandom_range(1, 0) == 1) || !ref_mem.exists(widx(a));
         d  = $urandom();
         access(0, !wr, wr, a, d, done_at, wl, ol, rdw, w0, w1);
         checks++; if (done_at !== 5) begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=5", i, done_at); end
         if (wr) begin
            ref_mem[widx(a)] = d;
            checks++;
            if (wl !== 2 || w0 !== {a[AW:2], 1'b0} || w1 !== {a[AW:2], 1'b1}) begin
               failures++; $display("FAIL rand_write i=%0d got=we%0d %h,%h exp=we2 %h,%h", i, wl, w0, w1, {a[AW:2], 1'b0}, {a[AW:2], 1'b1});
            end
         end else begin
            checks++;
            if (rdw !== ref_mem[widx(a)] || wl !== 0) begin
               failures++; $display("FAIL rand_read i=%0d got=%h we%0d exp=%h we0", i, rdw, wl, ref_mem[widx(a)]);
            end
         end
         gap = int'($urandom_range(2, 0));
         if (gap > 0) begin
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            repeat (gap) begin @(posedge clk); #1; end
         end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_reset_mid_write();
      test_req_drop();
      test_acc4();
      test_idle_illegal();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
